// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Operands are latched at accept and held on alu_* until the next accept; result/flag are registered.
module alu_req_arbiter #(
    parameter int WIDTH       = 32,
    parameter int OP_W        = 2,
    parameter int CMD_W       = 6,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [2*OP_W-1:0]    req_op,
    input  logic [2*CMD_W-1:0]   req_cmd,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic [3:0]           rsp_flag,
    output logic [WIDTH-1:0]     alu_A,
    output logic [WIDTH-1:0]     alu_B,
    output logic [OP_W-1:0]      alu_op,
    output logic [CMD_W-1:0]     alu_cmd,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [3:0]           alu_flag,
    output logic                 busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t             state_q;
    logic               prio_q;
    logic               id_q;
    logic [3:0]         cnt_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [OP_W-1:0]    op_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [3:0]         flag_q;

    logic               grant_d;
    logic [1:0]         rdy_d;

    // Priority holder wins if asking; otherwise the other side may take the slot.
    always_comb begin
        grant_d = req_valid[prio_q] ? prio_q : ~prio_q;
        rdy_d   = 2'b00;
        if (state_q == S_IDLE && !rst && req_valid[grant_d])
            rdy_d[grant_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cmd_q   <= '0;
            res_q   <= '0;
            flag_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rdy_d != 2'b00) begin
                        a_q     <= grant_d ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
                        b_q     <= grant_d ? req_b[2*WIDTH-1:WIDTH]   : req_b[WIDTH-1:0];
                        op_q    <= grant_d ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
                        cmd_q   <= grant_d ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
                        id_q    <= grant_d;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        res_q   <= alu_result;
                        flag_q  <= alu_flag;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[id_q]) begin
                        prio_q  <= ~id_q;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = rdy_d;
    assign rsp_valid  = (state_q == S_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = res_q;
    assign rsp_flag   = flag_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_op     = op_q;
    assign alu_cmd    = cmd_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: EXEC_CYCLES=1 and =4 instances share stimulus, each
// tracked by a transaction-level model; plus a directed table and corner sequences.
module tb_alu_req_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_op;
    logic [11:0] req_cmd;

    logic [1:0]  rdy [2];
    logic [1:0]  rv  [2];
    logic [31:0] res [2];
    logic [3:0]  flg [2];
    logic [31:0] aA  [2];
    logic [31:0] aB  [2];
    logic [1:0]  aop [2];
    logic [5:0]  acmd[2];
    logic [31:0] ares[2];
    logic [3:0]  aflg[2];
    logic        bsy [2];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // ALU stubs: result = A+B, flag = {zero,3'b0}
    assign ares[0] = aA[0] + aB[0];
    assign ares[1] = aA[1] + aB[1];
    assign aflg[0] = {ares[0] == 32'd0, 3'b000};
    assign aflg[1] = {ares[1] == 32'd0, 3'b000};

    alu_req_arbiter #(.WIDTH(32), .OP_W(2), .CMD_W(6), .EXEC_CYCLES(1)) u_ec1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cmd(req_cmd),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_result(res[0]), .rsp_flag(flg[0]),
        .alu_A(aA[0]), .alu_B(aB[0]), .alu_op(aop[0]), .alu_cmd(acmd[0]),
        .alu_result(ares[0]), .alu_flag(aflg[0]), .busy(bsy[0]));

    alu_req_arbiter #(.WIDTH(32), .OP_W(2), .CMD_W(6), .EXEC_CYCLES(4)) u_ec4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cmd(req_cmd),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_result(res[1]), .rsp_flag(flg[1]),
        .alu_A(aA[1]), .alu_B(aB[1]), .alu_op(aop[1]), .alu_cmd(acmd[1]),
        .alu_result(ares[1]), .alu_flag(aflg[1]), .busy(bsy[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding op per instance, response due EC edges after accept.
    bit          m_busy[2], m_id[2], m_prio[2];
    logic [31:0] m_A[2], m_B[2], m_exp[2], m_res[2];
    logic [1:0]  m_op[2];
    logic [5:0]  m_cmd[2];
    logic [3:0]  m_flag[2];
    int          m_at[2];
    logic [1:0]  e_rdy[2], e_rv[2];
    int          cyc = 0;

    initial begin : model_upd
        bit idx;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    m_busy[d] = 0; m_id[d] = 0; m_prio[d] = 0;
                    m_A[d] = 0; m_B[d] = 0; m_op[d] = 0; m_cmd[d] = 0;
                    m_res[d] = 0; m_flag[d] = 0; m_exp[d] = 0; m_at[d] = 0;
                    e_rdy[d] = 0; e_rv[d] = 0;
                end
            end else begin
                cyc++;
                for (int d = 0; d < 2; d++) begin
                    if (e_rdy[d] != 2'b00) begin
                        idx       = e_rdy[d][1];
                        m_A[d]    = idx ? req_a[63:32] : req_a[31:0];
                        m_B[d]    = idx ? req_b[63:32] : req_b[31:0];
                        m_op[d]   = idx ? req_op[3:2]  : req_op[1:0];
                        m_cmd[d]  = idx ? req_cmd[11:6] : req_cmd[5:0];
                        m_exp[d]  = m_A[d] + m_B[d];
                        m_id[d]   = idx;
                        m_busy[d] = 1;
                        m_at[d]   = cyc + ((d == 0) ? 1 : 4);
                    end else if (e_rv[d] != 2'b00 && rsp_ready[m_id[d]]) begin
                        m_busy[d] = 0;
                        m_prio[d] = ~m_id[d];
                    end
                    e_rdy[d] = 0;
                    e_rv[d]  = 0;
                end
            end
        end
    end

    initial begin : model_chk
        bit    g;
        string tg;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 2; d++) begin
                    tg = (d == 0) ? "ec1" : "ec4";
                    e_rdy[d] = 2'b00;
                    if (!m_busy[d] && req_valid != 2'b00) begin
                        g = req_valid[m_prio[d]] ? m_prio[d] : ~m_prio[d];
                        e_rdy[d] = g ? 2'b10 : 2'b01;
                    end
                    e_rv[d] = 2'b00;
                    if (m_busy[d] && cyc >= m_at[d]) begin
                        e_rv[d]   = m_id[d] ? 2'b10 : 2'b01;
                        m_res[d]  = m_exp[d];
                        m_flag[d] = {m_exp[d] == 32'd0, 3'b000};
                    end
                    chk({tg, ".req_ready"}, rdy[d], e_rdy[d]);
                    chk({tg, ".rsp_valid"}, rv[d], e_rv[d]);
                    chk({tg, ".busy"}, bsy[d], m_busy[d]);
                    chk({tg, ".rsp_result"}, res[d], m_res[d]);
                    chk({tg, ".rsp_flag"}, flg[d], m_flag[d]);
                    chk({tg, ".alu_A"}, aA[d], m_A[d]);
                    chk({tg, ".alu_B"}, aB[d], m_B[d]);
                    chk({tg, ".alu_opcmd"}, {aop[d], acmd[d]}, {m_op[d], m_cmd[d]});
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  rr, e_rdy, e_rv;
        logic [31:0] e_res;
    } vec_t;
    vec_t tab[21];

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, b0, a1, b1, input logic [1:0] rr);
        @(posedge clk); #1;
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        rsp_ready = rr;
    endtask

    task automatic wait_idle();
        bit done = 0;
        drive(2'b00, 0, 0, 0, 0, 2'b11);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bsy[0] && !bsy[1]) done = 1;
        end
        chk("idle_wait", done, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, ".req_ready"}, rdy[d], 0);
            chk({nm, ".rsp_valid"}, rv[d], 0);
            chk({nm, ".busy"}, bsy[d], 0);
            chk({nm, ".result_flag"}, {res[d], flg[d]}, 0);
            chk({nm, ".alu"}, {aA[d], aB[d], aop[d], acmd[d]}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // r0 single, r1 single, contention with r0 backpressure, alternation
        tab[0]  = '{2'b01, 14, 45,  0,  0, 2'b11, 2'b01, 2'b00, 0};
        tab[1]  = '{2'b00,  0,  0,  0,  0, 2'b11, 2'b00, 2'b00, 0};
        tab[2]  = '{2'b00,  0,  0,  0,  0, 2'b11, 2'b00, 2'b01, 59};
        tab[3]  = '{2'b10,  0,  0,  1,  2, 2'b11, 2'b10, 2'b00, 59};
        tab[4]  = '{2'b00,  0,  0,  0,  0, 2'b11, 2'b00, 2'b00, 59};
        tab[5]  = '{2'b00,  0,  0,  0,  0, 2'b11, 2'b00, 2'b10, 3};
        tab[6]  = '{2'b11, 87, 51, 26, 35, 2'b00, 2'b01, 2'b00, 3};
        tab[7]  = '{2'b11, 87, 51, 26, 35, 2'b00, 2'b00, 2'b00, 3};
        tab[8]  = '{2'b11, 87, 51, 26, 35, 2'b10, 2'b00, 2'b01, 138};
        tab[9]  = '{2'b11, 87, 51, 26, 35, 2'b10, 2'b00, 2'b01, 138};
        tab[10] = '{2'b11, 87, 51, 26, 35, 2'b10, 2'b00, 2'b01, 138};
        tab[11] = '{2'b11, 87, 51, 26, 35, 2'b10, 2'b00, 2'b01, 138};
        tab[12] = '{2'b11, 87, 51, 26, 35, 2'b10, 2'b00, 2'b01, 138};
        tab[13] = '{2'b11, 87, 51, 26, 35, 2'b01, 2'b00, 2'b01, 138};
        tab[14] = '{2'b11, 87, 51, 26, 35, 2'b11, 2'b10, 2'b00, 138};
        tab[15] = '{2'b11, 87, 51, 26, 35, 2'b11, 2'b00, 2'b00, 138};
        tab[16] = '{2'b11, 87, 51, 26, 35, 2'b11, 2'b00, 2'b10, 61};
        tab[17] = '{2'b11, 87, 51, 26, 35, 2'b11, 2'b01, 2'b00, 61};
        tab[18] = '{2'b00,  0,  0,  0,  0, 2'b11, 2'b00, 2'b00, 61};
        tab[19] = '{2'b00,  0,  0,  0,  0, 2'b11, 2'b00, 2'b01, 138};
        tab[20] = '{2'b00,  0,  0,  0,  0, 2'b11, 2'b00, 2'b00, 138};

        rst = 1'b1; req_valid = 0; rsp_ready = 0; req_a = 0; req_b = 0; req_op = 0; req_cmd = 0;
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(tab[i].v, tab[i].a0, tab[i].b0, tab[i].a1, tab[i].b1, tab[i].rr);
            @(negedge clk);
            chk($sformatf("tab%0d.req_ready", i), rdy[0], tab[i].e_rdy);
            chk($sformatf("tab%0d.rsp_valid", i), rv[0], tab[i].e_rv);
            chk($sformatf("tab%0d.rsp_result", i), res[0], tab[i].e_res);
            chk($sformatf("tab%0d.rsp_flag", i), flg[0], 0);
        end

        // EXEC_CYCLES=4: operands stay put while req_a churns; zero result sets flag
        wait_idle();
        drive(2'b01, 0, 0, 0, 0, 2'b11);
        @(negedge clk);
        chk("ec4.zero.accept", rdy[1], 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_a     = {$urandom, $urandom};
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("ec4.hold%0d.rsp_valid", j), rv[1], 0);
            chk($sformatf("ec4.hold%0d.alu_A", j), aA[1], 0);
            @(posedge clk); #1;
            req_a = {$urandom, $urandom};
        end
        @(negedge clk);
        chk("ec4.zero.rsp_valid", rv[1], 2'b01);
        chk("ec4.zero.flag", flg[1], 4'b1000);
        chk("ec4.zero.result", res[1], 0);

        // reset while ops in flight with r1 still pending
        wait_idle();
        drive(2'b11, 5, 6, 7, 8, 2'b00);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("midrst.hold.rsp_valid", {rv[1], rv[0]}, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst.ec1.grant", rdy[0], 2'b01);
        chk("postrst.ec4.grant", rdy[1], 2'b01);

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 249) == 0);
            req_valid = 2'($urandom_range(0, 3));
            req_a     = {($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
                         ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom};
            req_b     = {($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
                         ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom};
            req_op    = 4'($urandom);
            req_cmd   = 12'($urandom);
            rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
